regfile_mp: RTL

Parametrised multi-port register file, the successor to the 32x64 single-write/dual-read regfile of the ARM datapath. It generalises data width, register count, read-port count and write-port count. It keeps the hardwired zero register (XZR) and the index-valued reset image. It adds a per-register "written since reset" tracking vector, and optional same-cycle write-to-read forwarding for pipelined datapath use.

---
 rtl/regfile_mp_if.sv | 23 ++
 rtl/regfile_mp.sv | 102 ++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Register-file port bundle: read addresses/data, write ports, dirty vector.
// Latency: none, this file only groups signals.
// Backpressure: none; every port is accepted on every cycle.
interface regfile_mp_if #(
  parameter int DW   = 64,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2,
  parameter int NWR  = 1
);
  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic [NWR-1:0]    we;
  logic [NWR*AW-1:0] wa;
  logic [NWR*DW-1:0] wd;
  logic [NREG-1:0]   dirty;
  logic              clr_dirty;

  // The datapath side drives addresses, write data and the dirty clear.
  modport master (output ra, we, wa, wd, clr_dirty, input rd, dirty);
  // The register file answers with read data and the dirty vector.
  modport slave  (input ra, we, wa, wd, clr_dirty, output rd, dirty);
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired zero register and per-register dirty bits.
// Latency: reads are combinational (0 cycles); writes land on the next rising edge.
// Backpressure: none; define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp #(
  parameter int DW     = 64,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int ZR_IDX = 31,
  parameter int ZR_EN  = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);

  localparam logic [AW:0]   NREG_L = (AW+1)'(NREG);
  localparam logic [AW-1:0] ZR_L   = AW'(ZR_IDX);
  localparam bit            ZR_ON  = (ZR_EN != 0);

  // Illegal configurations are rejected at elaboration time.
  if (NWR < 1 || NWR > 2) begin : g_bad_nwr
    $error("regfile_mp: NWR must be 1..2");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_mp: NRD must be 1..4");
  end
  if (NREG < 2 || NREG > 64) begin : g_bad_nreg
    $error("regfile_mp: NREG must be 2..64");
  end
  if (ZR_EN != 0 && ZR_IDX >= NREG) begin : g_bad_zr
    $error("regfile_mp: ZR_IDX must be below NREG when ZR_EN=1");
  end

  logic [DW-1:0]     regs [NREG];
  logic [NREG-1:0]   dirty_q;
  logic [NREG-1:0]   dirty_set;
  logic [NWR-1:0]    land;
  logic [NRD*DW-1:0] rd_c;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_val;

  // An address is live if it exists and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG_L) && !(ZR_ON && (a == ZR_L));
  endfunction

  // Decide which write ports land this cycle and which dirty bits they set.
  always_comb begin
    land      = '0;
    dirty_set = '0;
    for (int k = 0; k < NWR; k++) begin
      land[k] = bus.we[k] && addr_ok(bus.wa[k*AW +: AW]);
      if (land[k]) dirty_set[bus.wa[k*AW +: AW]] = 1'b1;
    end
  end

  // Array update: reset loads the index image; later write ports override earlier ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (ZR_ON && (i == ZR_IDX)) ? '0 : DW'(i);
      end
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (land[k]) regs[bus.wa[k*AW +: AW]] <= bus.wd[k*DW +: DW];
      end
    end
  end

  // Dirty tracking: a landing write beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)              dirty_q <= '0;
    else if (bus.clr_dirty) dirty_q <= dirty_set;
    else                    dirty_q <= dirty_q | dirty_set;
  end

  // Read ports: zero register and nonexistent registers read as 0.
  always_comb begin
    rd_c    = '0;
    rd_addr = '0;
    rd_val  = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_addr = bus.ra[p*AW +: AW];
      rd_val  = '0;
      if (addr_ok(rd_addr)) begin
        rd_val = regs[rd_addr];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NWR; k++) begin
          if (land[k] && (bus.wa[k*AW +: AW] == rd_addr)) rd_val = bus.wd[k*DW +: DW];
        end
`endif
      end
      rd_c[p*DW +: DW] = rd_val;
    end
  end

  assign bus.rd    = rd_c;
  assign bus.dirty = dirty_q;

endmodule
